// File: rtl/iir_biquad_sched_pkg.sv
// -----------------------------------------------------------------------------
// iir_pkg
// Shared types and helpers for the time-multiplexed biquad cascade sequencer:
// FSM state encoding, tap ordering inside a section, the bypass coefficient
// set and the round/saturate step applied at the end of every section.
// -----------------------------------------------------------------------------
package iir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_SEC_END,
        ST_OUT
    } state_t;

    // Tap order inside one section; also the coefficient address offset.
    localparam int TAP_B0   = 0;
    localparam int TAP_B1   = 1;
    localparam int TAP_B2   = 2;
    localparam int TAP_A1   = 3;
    localparam int TAP_A2   = 4;
    localparam int NUM_TAPS = 5;

    // Bypass section: b0 = 1.0 in the coefficient fixed-point format, rest 0.
    function automatic logic signed [63:0] bypass_coef(input int tap, input int coef_frac);
        return (tap == TAP_B0) ? (64'sd1 <<< coef_frac) : 64'sd0;
    endfunction

    // Round half up, drop coef_frac fraction bits, clamp to a wd_data-bit
    // signed range. The accumulator is passed sign-extended to 64 bits.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                     input int coef_frac,
                                                     input int wd_data);
        logic signed [63:0] rounded;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        rounded = (acc + (64'sd1 <<< (coef_frac - 1))) >>> coef_frac;
        max_v   = (64'sd1 <<< (wd_data - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (wd_data - 1));
        if (rounded > max_v)      return max_v;
        else if (rounded < min_v) return min_v;
        else                      return rounded;
    endfunction

endpackage

// File: rtl/iir_biquad_sched_if.sv
// -----------------------------------------------------------------------------
// iir_biquad_sched_if
// Sample stream (valid/ready in and out) plus the coefficient write port.
//   in_valid/in_ready/in_data     : input samples, source -> filter
//   out_valid/out_ready/out_data  : filtered samples, filter -> sink
//   cfg_we/cfg_addr/cfg_data      : coefficient writes (addr = sec*5 + tap)
//   cfg_err                       : one-cycle pulse for a rejected write
// master = sample source / software side, slave = the filter.
// -----------------------------------------------------------------------------
interface iir_biquad_sched_if #(
    parameter int WD_DATA = 24,
    parameter int WD_COEF = 18,
    parameter int WD_ADDR = 4
);
    logic                       in_valid;
    logic                       in_ready;
    logic signed [WD_DATA-1:0]  in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [WD_DATA-1:0]  out_data;
    logic                       cfg_we;
    logic        [WD_ADDR-1:0]  cfg_addr;
    logic signed [WD_COEF-1:0]  cfg_data;
    logic                       cfg_err;

    modport master (
        output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_valid, out_data, cfg_err
    );

    modport slave (
        input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_valid, out_data, cfg_err
    );
endinterface

// File: rtl/iir_biquad_sched_mac.sv
// -----------------------------------------------------------------------------
// iir_mac
// Shared multiply-accumulate unit: one signed a*b product per cycle, added to
// or subtracted from a registered full-width accumulator.
//   clk, reset : clock, asynchronous active-high reset
//   acc_clr    : zero the accumulator (wins over acc_en)
//   acc_en     : accumulate this cycle's product
//   sub        : subtract instead of add
//   a, b       : signed sample / coefficient operands
//   acc        : accumulator value
// -----------------------------------------------------------------------------
module iir_mac #(
    parameter int WD_A   = 24,
    parameter int WD_B   = 18,
    parameter int WD_ACC = 46
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     acc_clr,
    input  logic                     acc_en,
    input  logic                     sub,
    input  logic signed [WD_A-1:0]   a,
    input  logic signed [WD_B-1:0]   b,
    output logic signed [WD_ACC-1:0] acc
);
    logic signed [WD_A+WD_B-1:0] prod;
    logic signed [WD_ACC-1:0]    prod_ext;

    assign prod     = a * b;
    assign prod_ext = WD_ACC'(prod);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       acc <= '0;
        else if (acc_clr) acc <= '0;
        else if (acc_en)  acc <= sub ? (acc - prod_ext) : (acc + prod_ext);
    end
endmodule

// File: rtl/iir_biquad_sched.sv
// -----------------------------------------------------------------------------
// iir_biquad_sched
// Sequencer for a cascade of NUM_SEC Direct Form I biquads sharing one MAC.
// Each section takes 5 MAC cycles plus one round/saturate/history cycle, so a
// sample appears NUM_SEC*6 cycles after it is accepted.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : sample stream and coefficient port (slave side)
//   clear      : synchronous pulse, zero history and abort the current sample
//   busy       : high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module iir_biquad_sched
    import iir_pkg::*;
#(
    parameter int WD_DATA   = 24,
    parameter int WD_COEF   = 18,
    parameter int COEF_FRAC = 16,
    parameter int NUM_SEC   = 2,
    parameter int WD_ACC    = WD_DATA + WD_COEF + 4   // must stay <= 64
) (
    input  logic                clk,
    input  logic                reset,
    iir_biquad_sched_if.slave   bus,
    input  logic                clear,
    output logic                busy
);
    localparam int NUM_COEF = NUM_SEC * NUM_TAPS;
    localparam int WD_ADDR  = $clog2(NUM_COEF);
    localparam int WD_SEC   = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;

    state_t                     state, state_next;
    logic        [WD_SEC-1:0]   sec;
    logic        [2:0]          tap;
    logic signed [WD_DATA-1:0]  x_cur;
    logic signed [WD_DATA-1:0]  x1 [NUM_SEC];
    logic signed [WD_DATA-1:0]  x2 [NUM_SEC];
    logic signed [WD_DATA-1:0]  y1 [NUM_SEC];
    logic signed [WD_DATA-1:0]  y2 [NUM_SEC];
    logic signed [WD_COEF-1:0]  coef [NUM_COEF];
    logic signed [WD_ACC-1:0]   acc;
    logic signed [WD_DATA-1:0]  mac_a;
    logic signed [WD_COEF-1:0]  mac_b;
    logic signed [WD_DATA-1:0]  y_sat;
    logic signed [WD_DATA-1:0]  out_data;
    logic        [WD_ADDR-1:0]  coef_idx;
    logic                       acc_clr, acc_en, mac_sub;
    logic                       accept, last_sec, last_tap, addr_ok, cfg_err;

    assign busy          = (state != ST_IDLE);
    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_OUT);
    assign bus.out_data  = out_data;
    assign bus.cfg_err   = cfg_err;

    // clear outranks a simultaneous input handshake: the sample is dropped.
    assign accept   = (state == ST_IDLE) && bus.in_valid && !clear;
    assign last_sec = (sec == WD_SEC'(NUM_SEC - 1));
    assign last_tap = (tap == 3'(TAP_A2));
    assign addr_ok  = (int'(bus.cfg_addr) < NUM_COEF);
    assign coef_idx = WD_ADDR'(int'(sec) * NUM_TAPS + int'(tap));
    assign mac_b    = coef[coef_idx];
    assign y_sat    = WD_DATA'(round_sat(64'(acc), COEF_FRAC, WD_DATA));

    // Operand for the current tap: new input, input history, output history.
    always_comb begin
        mac_a = x_cur;
        case (int'(tap))
            TAP_B1:  mac_a = x1[sec];
            TAP_B2:  mac_a = x2[sec];
            TAP_A1:  mac_a = y1[sec];
            TAP_A2:  mac_a = y2[sec];
            default: mac_a = x_cur;
        endcase
    end

    iir_mac #(
        .WD_A   (WD_DATA),
        .WD_B   (WD_COEF),
        .WD_ACC (WD_ACC)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .acc_clr (acc_clr),
        .acc_en  (acc_en),
        .sub     (mac_sub),
        .a       (mac_a),
        .b       (mac_b),
        .acc     (acc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        mac_sub    = 1'b0;
        if (clear) begin
            state_next = ST_IDLE;
            acc_clr    = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    acc_clr = 1'b1;
                    if (accept) state_next = ST_MAC;
                end
                ST_MAC: begin
                    acc_en  = 1'b1;
                    mac_sub = (tap >= 3'(TAP_A1));
                    if (last_tap) state_next = ST_SEC_END;
                end
                ST_SEC_END: begin
                    acc_clr    = 1'b1;
                    state_next = last_sec ? ST_OUT : ST_MAC;
                end
                ST_OUT: begin
                    if (bus.out_ready) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec      <= '0;
            tap      <= '0;
            x_cur    <= '0;
            out_data <= '0;
            cfg_err  <= 1'b0;
            for (int s = 0; s < NUM_SEC; s++) begin
                x1[s] <= '0;
                x2[s] <= '0;
                y1[s] <= '0;
                y2[s] <= '0;
            end
            // NOTE: the coefficient file is reset on purpose: after reset
            // the cascade must behave as a bypass, so it cannot be left as
            // an uninitialised RAM.
            for (int i = 0; i < NUM_COEF; i++)
                coef[i] <= WD_COEF'(bypass_coef(i % NUM_TAPS, COEF_FRAC));
        end else begin
            cfg_err <= bus.cfg_we && (busy || !addr_ok);
            // Writes only land while idle, so coefficients never move mid-sample.
            if (bus.cfg_we && !busy && addr_ok)
                coef[bus.cfg_addr] <= bus.cfg_data;

            if (clear) begin
                for (int s = 0; s < NUM_SEC; s++) begin
                    x1[s] <= '0;
                    x2[s] <= '0;
                    y1[s] <= '0;
                    y2[s] <= '0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            x_cur <= bus.in_data;
                            sec   <= '0;
                            tap   <= '0;
                        end
                    end
                    ST_MAC: tap <= last_tap ? 3'd0 : tap + 3'd1;
                    ST_SEC_END: begin
                        x2[sec] <= x1[sec];
                        x1[sec] <= x_cur;
                        y2[sec] <= y1[sec];
                        y1[sec] <= y_sat;
                        if (last_sec) begin
                            out_data <= y_sat;
                        end else begin
                            sec   <= sec + 1'b1;
                            x_cur <= y_sat;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_iir_biquad_sched.sv
// -----------------------------------------------------------------------------
// tb_iir_biquad_sched
// Directed vector table, hand-written corner sequences (coincident write and
// accept, rejected writes, backpressure, reset and clear mid-sample) and a
// randomized phase checked against a plain-arithmetic cascade model.
// -----------------------------------------------------------------------------
module tb_iir_biquad_sched;
    localparam int WD_DATA   = 24;
    localparam int WD_COEF   = 18;
    localparam int COEF_FRAC = 16;
    localparam int NUM_SEC   = 2;
    localparam int NUM_COEF  = NUM_SEC * 5;
    localparam int WD_ADDR   = 4;
    localparam int LATENCY   = NUM_SEC * 6;

    logic clk = 1'b0;
    logic reset;
    logic clear;
    logic busy;

    always #5 clk = ~clk;

    iir_biquad_sched_if #(.WD_DATA(WD_DATA), .WD_COEF(WD_COEF), .WD_ADDR(WD_ADDR)) bus ();

    iir_biquad_sched #(
        .WD_DATA   (WD_DATA),
        .WD_COEF   (WD_COEF),
        .COEF_FRAC (COEF_FRAC),
        .NUM_SEC   (NUM_SEC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .clear (clear),
        .busy  (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: the cascade as plain arithmetic ----------
    longint m_coef [NUM_COEF];
    longint m_x1 [NUM_SEC];
    longint m_x2 [NUM_SEC];
    longint m_y1 [NUM_SEC];
    longint m_y2 [NUM_SEC];

    function automatic longint sx(input longint v, input int w);
        longint m;
        m = v & ((longint'(1) << w) - 1);
        if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
        return m;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < NUM_SEC; s++) begin
            m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_COEF; i++)
            m_coef[i] = ((i % 5) == 0) ? (longint'(1) << COEF_FRAC) : 0;
        model_clear();
    endtask

    function automatic logic [23:0] model_sample(input logic [23:0] din);
        longint x, acc, y;
        x = sx(longint'(din), WD_DATA);
        for (int s = 0; s < NUM_SEC; s++) begin
            acc = m_coef[s*5+0] * x + m_coef[s*5+1] * m_x1[s] + m_coef[s*5+2] * m_x2[s]
                - m_coef[s*5+3] * m_y1[s] - m_coef[s*5+4] * m_y2[s];
            y = (acc + (longint'(1) << (COEF_FRAC - 1))) >>> COEF_FRAC;
            if (y > 64'sd8388607)  y = 64'sd8388607;
            if (y < -64'sd8388608) y = -64'sd8388608;
            m_x2[s] = m_x1[s]; m_x1[s] = x;
            m_y2[s] = m_y1[s]; m_y1[s] = y;
            x = y;
        end
        return x[23:0];
    endfunction

    // ---------------- stimulus helpers ------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int addr, input int data, input bit exp_err);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = WD_ADDR'(addr);
        bus.cfg_data = WD_COEF'(data);
        tick();
        bus.cfg_we = 1'b0;
        check($sformatf("cfg_err_a%0d", addr), bus.cfg_err, exp_err);
        if (!exp_err) m_coef[addr] = sx(longint'(data), WD_COEF);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
    endtask

    task automatic accept(input logic [23:0] din);
        int guard = 0;
        while (!bus.in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!bus.in_ready) check("accept_wait", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = din;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [23:0] dout, output int lat, output bit ir_bad);
        lat    = 0;
        ir_bad = 1'b0;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready) ir_bad = 1'b1;
            tick();
            lat++;
        end
        dout = bus.out_data;
    endtask

    task automatic run_sample(input string name, input logic [23:0] din, input logic [23:0] exp);
        logic [23:0] dout;
        int          lat;
        bit          ir_bad;
        accept(din);
        wait_result(dout, lat, ir_bad);
        check(name, dout, exp);
        check({name, "_latency"}, lat, LATENCY);
        check({name, "_in_ready_low"}, ir_bad, 1'b0);
        if (bus.out_ready) tick();
    endtask

    typedef struct {
        bit          clr;
        bit          we;
        int          addr;
        int          coef;
        bit          send;
        logic [23:0] din;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [23:0] dout, d0, exp;
        int          lat;
        bit          ir_bad, stab_bad, err_seen, ov_seen;

        vecs[0] = '{0, 0, 0, 0,       1, 24'h123456, 24'h123456};
        vecs[1] = '{0, 1, 0, 'h08000, 1, 24'h100000, 24'h080000};
        vecs[2] = '{0, 1, 0, 'h1FFFF, 1, 24'h7FFFFF, 24'h7FFFFF};
        vecs[3] = '{0, 0, 0, 0,       1, 24'h800000, 24'h800000};
        vecs[4] = '{1, 1, 0, 'h10000, 0, 24'h000000, 24'h000000};
        vecs[5] = '{0, 1, 3, 'h38000, 1, 24'h400000, 24'h400000};
        vecs[6] = '{0, 0, 0, 0,       1, 24'h000000, 24'h200000};
        vecs[7] = '{0, 0, 0, 0,       1, 24'h000000, 24'h100000};
        vecs[8] = '{0, 0, 0, 0,       1, 24'h000000, 24'h080000};

        reset        = 1'b1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b1;
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_in_ready",  bus.in_ready,  1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data",  bus.out_data,  24'h0);
        check("rst_cfg_err",   bus.cfg_err,   1'b0);
        check("rst_busy",      busy,          1'b0);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].clr) pulse_clear();
            if (vecs[i].we) cfg_write(vecs[i].addr, vecs[i].coef, 1'b0);
            if (vecs[i].send) begin
                void'(model_sample(vecs[i].din));
                run_sample($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp);
            end
        end

        // Coefficient write coincident with accept: new b0 applies to this sample
        cfg_write(3, 0, 1'b0);
        pulse_clear();
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 4'd0;
        bus.cfg_data = 18'h08000;
        bus.in_valid = 1'b1;
        bus.in_data  = 24'h100000;
        tick();
        bus.cfg_we   = 1'b0;
        bus.in_valid = 1'b0;
        check("coincident_cfg_err", bus.cfg_err, 1'b0);
        m_coef[0] = 'h08000;
        void'(model_sample(24'h100000));
        wait_result(dout, lat, ir_bad);
        check("coincident_out", dout, 24'h080000);
        check("coincident_latency", lat, LATENCY);
        tick();
        cfg_write(0, 'h10000, 1'b0);

        // Out-of-range address: rejected, one-cycle error pulse
        cfg_write(10, 'h12345, 1'b1);
        tick();
        check("cfg_err_pulse_end", bus.cfg_err, 1'b0);
        exp = model_sample(24'h0ABCDE);
        run_sample("after_bad_addr", 24'h0ABCDE, exp);

        // Backpressure: output held 10 cycles, write during it is rejected
        bus.out_ready = 1'b0;
        exp = model_sample(24'h2468AC);
        accept(24'h2468AC);
        wait_result(d0, lat, ir_bad);
        check("bp_out", d0, exp);
        stab_bad = 1'b0; ir_bad = 1'b0; err_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.cfg_we   = (i == 2);
            bus.cfg_addr = 4'd0;
            bus.cfg_data = 18'h08000;
            tick();
            bus.cfg_we = 1'b0;
            if (bus.out_data !== d0 || !bus.out_valid) stab_bad = 1'b1;
            if (bus.in_ready) ir_bad = 1'b1;
            if (i == 2) err_seen = bus.cfg_err;
        end
        check("bp_stable", stab_bad, 1'b0);
        check("bp_in_ready_low", ir_bad, 1'b0);
        check("bp_cfg_err", err_seen, 1'b1);
        bus.out_ready = 1'b1;
        tick();
        check("bp_released", bus.out_valid, 1'b0);
        exp = model_sample(24'h100000);
        run_sample("bp_coef_kept", 24'h100000, exp);

        // Randomized phase against the model
        for (int i = 0; i < 24; i++) begin
            logic [23:0] din;
            if ($urandom_range(0, 2) == 0)
                cfg_write(int'($urandom_range(0, NUM_COEF - 1)),
                          int'($urandom_range(0, 'h10000)) - 'h8000, 1'b0);
            din = 24'($urandom);
            exp = model_sample(din);
            run_sample($sformatf("rand%0d", i), din, exp);
        end

        // Reset mid-sample: immediate reset values, bypass coefficients back
        accept(24'h111111);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_busy",      busy,          1'b0);
        check("midrst_in_ready",  bus.in_ready,  1'b1);
        check("midrst_out_data",  bus.out_data,  24'h0);
        model_reset();
        tick();
        reset = 1'b0;
        tick();
        void'(model_sample(24'h123456));
        run_sample("after_reset", 24'h123456, 24'h123456);

        // Clear mid-sample: busy drops, no output, history zeroed
        cfg_write(1, 'h10000, 1'b0);
        exp = model_sample(24'h000100);
        run_sample("b1_sample", 24'h000100, exp);
        accept(24'h222222);
        repeat (4) tick();
        pulse_clear();
        check("clear_busy", busy, 1'b0);
        ov_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) ov_seen = 1'b1;
            tick();
        end
        check("clear_no_out", ov_seen, 1'b0);
        void'(model_sample(24'h123456));
        run_sample("after_clear", 24'h123456, 24'h123456);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
